// File: rtl/analytic_signal_gen.sv
// Analytic signal generator: Re is the input delayed to the FIR centre tap and Im is the
// Hilbert FIR output. Coefficients are loaded per run, and the tail is flushed before doneFlag.
module analytic_signal_gen #(
  parameter int LENGTH      = 27,
  parameter int DATA_WIDTH  = 18,
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_FRAC  = 15,
  parameter int OUT_WIDTH   = 36
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [COEFF_WIDTH-1:0] coeffIn,
  input  logic                          coeffValid,
  output logic                          coeffSetFlag,
  input  logic signed [DATA_WIDTH-1:0]  dataIn,
  input  logic                          dataInValid,
  input  logic                          stopDataInFlag,
  output logic                          dataOutValid,
  output logic signed [OUT_WIDTH-1:0]   dataOutRe,
  output logic signed [OUT_WIDTH-1:0]   dataOutIm,
  output logic                          doneFlag,
  output logic [2:0]                    debugState
);

  localparam int C      = (LENGTH - 1) / 2;
  localparam int CNT_W  = $clog2(LENGTH);
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(LENGTH);
  localparam int RE_W   = DATA_WIDTH + COEFF_FRAC;
  localparam int WIDE_A = (SUM_W > RE_W) ? SUM_W : RE_W;
  localparam int CMP_W  = ((WIDE_A > OUT_WIDTH) ? WIDE_A : OUT_WIDTH) + 1;
  localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, LOAD_COEFF, MAIN_OPP, FLUSH, DRAIN} state_t;

  state_t state, stateNext;
  logic [CNT_W-1:0] coeffCount, flushCount;
  logic signed [COEFF_WIDTH-1:0] h [LENGTH];
  logic signed [DATA_WIDTH-1:0]  x [LENGTH];
  logic signed [DATA_WIDTH-1:0]  xNext [LENGTH];
  logic signed [PROD_W-1:0]      prod [LENGTH];
  logic signed [DATA_WIDTH-1:0]  reCentre;
  logic signed [DATA_WIDTH-1:0]  shiftSample;
  logic signed [SUM_W-1:0]       sumAll;
  logic signed [CMP_W-1:0]       sumWide, reWide;
  logic valid1;
  logic startLoad, coeffWe, coeffDone, shiftEn, flushStart, flushStep, finish;

  assign debugState = state;

  // Handshakes are valid-only (no backpressure): a beat is taken on any rising edge where
  // its valid is high and the FSM is in the state that honours it; otherwise it is dropped.
  always_comb begin
    stateNext   = state;
    startLoad   = 1'b0;
    coeffWe     = 1'b0;
    coeffDone   = 1'b0;
    shiftEn     = 1'b0;
    shiftSample = dataIn;
    flushStart  = 1'b0;
    flushStep   = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: if (enable) begin
        startLoad = 1'b1;
        stateNext = LOAD_COEFF;
      end
      LOAD_COEFF: if (coeffValid) begin
        coeffWe = 1'b1;
        if (coeffCount == CNT_W'(LENGTH - 1)) begin
          coeffDone = 1'b1;
          stateNext = MAIN_OPP;
        end
      end
      MAIN_OPP: begin
        shiftEn = dataInValid;
        if (stopDataInFlag) begin
          flushStart = 1'b1;
          stateNext  = FLUSH;
        end
      end
      FLUSH: begin
        shiftEn     = 1'b1;
        shiftSample = '0;
        flushStep   = 1'b1;
        if (flushCount == CNT_W'(LENGTH - 2)) stateNext = DRAIN;
      end
      DRAIN: if (dataOutValid && !valid1) begin
        finish    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      coeffCount   <= '0;
      flushCount   <= '0;
      coeffSetFlag <= 1'b0;
      doneFlag     <= 1'b0;
    end else begin
      state    <= stateNext;
      doneFlag <= finish;
      if (startLoad) begin
        coeffCount   <= '0;
        coeffSetFlag <= 1'b0;
      end else if (coeffWe) begin
        coeffCount <= coeffCount + CNT_W'(1);
      end
      if (coeffDone) coeffSetFlag <= 1'b1;
      if (flushStart) flushCount <= '0;
      else if (flushStep) flushCount <= flushCount + CNT_W'(1);
    end
  end

  // Stage 1 multiplies against the post-shift window so latency stays at two edges.
  always_comb begin
    xNext = x;
    if (shiftEn) begin
      xNext[0] = shiftSample;
      for (int k = 1; k < LENGTH; k++) xNext[k] = x[k-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LENGTH; k++) begin
        h[k] <= '0;
        x[k] <= '0;
      end
    end else begin
      if (coeffWe) h[coeffCount] <= coeffIn;
      if (coeffDone) begin
        for (int k = 0; k < LENGTH; k++) x[k] <= '0;
      end else begin
        x <= xNext;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid1   <= 1'b0;
      reCentre <= '0;
      for (int k = 0; k < LENGTH; k++) prod[k] <= '0;
    end else begin
      valid1 <= shiftEn;
      if (shiftEn) begin
        reCentre <= xNext[C];
        for (int k = 0; k < LENGTH; k++) prod[k] <= PROD_W'(h[k]) * PROD_W'(xNext[k]);
      end
    end
  end

  always_comb begin
    sumAll = '0;
    for (int k = 0; k < LENGTH; k++) sumAll = sumAll + SUM_W'(prod[k]);
    sumWide = CMP_W'(sumAll);
    reWide  = CMP_W'(reCentre) <<< COEFF_FRAC;
  end

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [CMP_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[OUT_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    else                  return v[OUT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dataOutValid <= 1'b0;
      dataOutRe    <= '0;
      dataOutIm    <= '0;
    end else begin
      dataOutValid <= valid1;
      if (valid1) begin
        dataOutRe <= saturate(reWide);
        dataOutIm <= saturate(sumWide);
      end else begin
        dataOutRe <= '0;
        dataOutIm <= '0;
      end
    end
  end

endmodule

// File: tb/tb_analytic_signal_gen.sv
// Bench for analytic_signal_gen: three parameterisations share one stimulus stream;
// outputs are scored against hand-computed tables through expected queues.
module tb_analytic_signal_gen;

  localparam int LEN = 27;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_MAIN = 3'd2;

  typedef struct {
    logic signed [17:0] din;
    logic signed [35:0] expIm;
    logic signed [35:0] expRe;
  } vec_t;

  typedef struct {
    logic signed [35:0] im;
    logic signed [35:0] re;
    int                 inCyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic signed [17:0] coeffIn = '0;
  logic coeffValid = 1'b0;
  logic signed [17:0] dataIn = '0;
  logic dataInValid = 1'b0;
  logic stopDataInFlag = 1'b0;

  logic flagA, validA, doneA, flagD, validD, doneD, flagS, validS, doneS;
  logic [2:0] stateA, stateD, stateS;
  logic signed [35:0] reA, imA, reD, imD;
  logic signed [19:0] reS, imS;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int lastA = 0, lastS = 0, cntA = 0, cntS = 0;
  bit modeA = 1'b0, modeS = 1'b0;
  exp_t expA[$];
  exp_t expS[$];
  exp_t eA, eS;
  vec_t impulseVec[LEN];
  vec_t curVec[64];

  analytic_signal_gen #(.LENGTH(27), .COEFF_FRAC(0), .OUT_WIDTH(36)) dutA (
    .clock(clock), .reset(reset), .enable(enable), .coeffIn(coeffIn), .coeffValid(coeffValid),
    .coeffSetFlag(flagA), .dataIn(dataIn), .dataInValid(dataInValid),
    .stopDataInFlag(stopDataInFlag), .dataOutValid(validA), .dataOutRe(reA), .dataOutIm(imA),
    .doneFlag(doneA), .debugState(stateA));

  analytic_signal_gen dutD (
    .clock(clock), .reset(reset), .enable(enable), .coeffIn(coeffIn), .coeffValid(coeffValid),
    .coeffSetFlag(flagD), .dataIn(dataIn), .dataInValid(dataInValid),
    .stopDataInFlag(stopDataInFlag), .dataOutValid(validD), .dataOutRe(reD), .dataOutIm(imD),
    .doneFlag(doneD), .debugState(stateD));

  analytic_signal_gen #(.LENGTH(27), .COEFF_FRAC(0), .OUT_WIDTH(20)) dutS (
    .clock(clock), .reset(reset), .enable(enable), .coeffIn(coeffIn), .coeffValid(coeffValid),
    .coeffSetFlag(flagS), .dataIn(dataIn), .dataInValid(dataInValid),
    .stopDataInFlag(stopDataInFlag), .dataOutValid(validS), .dataOutRe(reS), .dataOutIm(imS),
    .doneFlag(doneS), .debugState(stateS));

  // Clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkVal(input string name, input logic signed [63:0] act,
                          input logic signed [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: pop one expected record per observed output.
  always @(negedge clock) begin
    if (validA) begin
      lastA = cyc;
      cntA++;
      if (modeA) begin
        if (expA.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_a: got valid with im=%0d, expected no output", imA);
        end else begin
          eA = expA.pop_front();
          checkVal("im_a", imA, eA.im);
          checkVal("re_a", reA, eA.re);
          checkVal("latency_a", cyc - eA.inCyc, 2);
          checkVal("valid_d", validD, 1);
          checkVal("im_d", imD, eA.im);
          checkVal("re_d", reD, eA.re <<< 15);
        end
      end
    end
    if (validS) begin
      lastS = cyc;
      cntS++;
      if (modeS) begin
        if (expS.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_s: got valid with im=%0d, expected no output", imS);
        end else begin
          eS = expS.pop_front();
          checkVal("im_s", imS, eS.im);
          checkVal("re_s", reS, eS.re);
          checkVal("latency_s", cyc - eS.inCyc, 2);
        end
      end
    end
  end

  task automatic pushExp(input bit useS, input logic signed [35:0] im,
                         input logic signed [35:0] re, input int inCyc);
    exp_t rec;
    rec.im = im;
    rec.re = re;
    rec.inCyc = inCyc;
    if (useS) expS.push_back(rec);
    else expA.push_back(rec);
  endtask

  // Driver: enable, then nBeats coefficient beats with ignored data pulses interleaved.
  task automatic loadCoeffs(input bit satCoeffs, input int nBeats);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checkVal("load_flag_clear", flagA, 0);
    checkVal("load_state", stateA, ST_LOAD);
    for (int k = 0; k < nBeats; k++) begin
      if (k % 5 == 2) begin
        dataIn = 18'sd777;
        dataInValid = 1'b1;
        tick();
        dataInValid = 1'b0;
      end
      coeffIn = satCoeffs ? 18'sd131071 : 18'(k + 1);
      coeffValid = 1'b1;
      tick();
      coeffValid = 1'b0;
      if (k == LEN - 2) checkVal("flag_before_last", flagA, 0);
      if (k == LEN - 1) begin
        checkVal("flag_after_last", flagA, 1);
        checkVal("flag_after_last_s", flagS, 1);
        checkVal("state_main", stateA, ST_MAIN);
      end
    end
  endtask

  task automatic waitDone(input bit useS, input int expCount);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      seen = useS ? doneS : doneA;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: doneFlag=0 after 100 cycles, expected a pulse");
    end else begin
      checkVal("done_cycle", cyc, (useS ? lastS : lastA) + 1);
      checkVal("out_count", useS ? cntS : cntA, expCount);
      checkVal("exp_left", useS ? expS.size() : expA.size(), 0);
      if (!useS) checkVal("done_d", doneD, 1);
      @(negedge clock);
      checkVal("done_pulse", useS ? doneS : doneA, 0);
      checkVal("state_idle", useS ? stateS : stateA, ST_IDLE);
      checkVal("flag_kept", useS ? flagS : flagA, 1);
    end
    tick();
  endtask

  // Apply curVec inputs, stop with the last sample, expect LEN-1 flushed outputs after.
  task automatic runStream(input int nSamples, input bit gapped, input bit useS);
    int s = 0;
    cntA = 0;
    cntS = 0;
    for (int n = 0; n < nSamples; n++) begin
      if (gapped && n > 0) begin
        dataIn = 18'sd1234;
        dataInValid = 1'b0;
        stopDataInFlag = 1'b0;
        tick();
      end
      dataIn = curVec[n].din;
      dataInValid = 1'b1;
      stopDataInFlag = (n == nSamples - 1);
      pushExp(useS, curVec[n].expIm, curVec[n].expRe, cyc);
      s = cyc;
      tick();
    end
    dataIn = '0;
    dataInValid = 1'b0;
    stopDataInFlag = 1'b0;
    for (int j = 0; j < LEN - 1; j++)
      pushExp(useS, curVec[nSamples + j].expIm, curVec[nSamples + j].expRe, s + 1 + j);
    waitDone(useS, nSamples + LEN - 1);
  endtask

  task automatic fillImpulse();
    for (int n = 0; n < 64; n++) begin
      if (n < LEN) curVec[n] = impulseVec[n];
      else begin
        curVec[n].din = '0;
        curVec[n].expIm = '0;
        curVec[n].expRe = '0;
      end
    end
  endtask

  task automatic fillSat(input logic signed [17:0] val);
    for (int n = 0; n < 64; n++) begin
      curVec[n].din = val;
      curVec[n].expIm = (val > 0) ? 36'sd524287 : -36'sd524288;
      curVec[n].expRe = (n >= 13 && n <= 16) ? 36'(val) : 36'sd0;
    end
  endtask

  initial begin
    // Impulse table: h[k]=k+1, input 5 then zeros -> Im=5(n+1), Re=5 at the centre tap only.
    for (int n = 0; n < LEN; n++) begin
      impulseVec[n].din = (n == 0) ? 18'sd5 : 18'sd0;
      impulseVec[n].expIm = 36'(5 * (n + 1));
      impulseVec[n].expRe = (n == 13) ? 36'sd5 : 36'sd0;
    end

    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkVal("rst_valid", validA, 0);
    checkVal("rst_im", imA, 0);
    checkVal("rst_re", reA, 0);
    checkVal("rst_flag", flagA, 0);
    checkVal("rst_done", doneA, 0);
    checkVal("rst_state", stateA, ST_IDLE);
    @(negedge clock) reset = 1'b0;
    tick();

    // Ignored inputs, then contiguous impulse
    modeA = 1'b1;
    repeat (3) begin
      dataIn = 18'sd777;
      dataInValid = 1'b1;
      tick();
    end
    dataInValid = 1'b0;
    checkVal("idle_hold", stateA, ST_IDLE);
    loadCoeffs(1'b0, LEN);
    repeat (3) begin
      coeffIn = 18'sd999;
      coeffValid = 1'b1;
      tick();
    end
    coeffValid = 1'b0;
    checkVal("main_hold", stateA, ST_MAIN);
    fillImpulse();
    runStream(LEN, 1'b0, 1'b0);

    // Gapped impulse
    loadCoeffs(1'b0, LEN);
    runStream(LEN, 1'b1, 1'b0);

    // Short stream: 5 samples + 26 flushed
    loadCoeffs(1'b0, LEN);
    runStream(5, 1'b0, 1'b0);

    // Saturation, positive then negative
    modeA = 1'b0;
    modeS = 1'b1;
    loadCoeffs(1'b1, LEN);
    fillSat(18'sd131071);
    runStream(4, 1'b0, 1'b1);
    loadCoeffs(1'b1, LEN);
    fillSat(-18'sd131072);
    runStream(4, 1'b0, 1'b1);
    modeS = 1'b0;

    // Asynchronous reset while an output is being presented
    loadCoeffs(1'b0, LEN);
    dataIn = 18'sd5;
    dataInValid = 1'b1;
    tick();
    dataIn = 18'sd0;
    tick();
    checkVal("pre_reset_valid", validA, 1);
    checkVal("pre_reset_im", imA, 5);
    #3 reset = 1'b1;
    dataInValid = 1'b0;
    #1;
    checkVal("async_valid", validA, 0);
    checkVal("async_im", imA, 0);
    checkVal("async_re", reA, 0);
    checkVal("async_flag", flagA, 0);
    checkVal("async_state", stateA, ST_IDLE);
    #2 reset = 1'b0;
    tick();

    // Asynchronous reset mid-load, then full reload and impulse
    modeA = 1'b1;
    expA.delete();
    loadCoeffs(1'b0, 10);
    #3 reset = 1'b1;
    #1;
    checkVal("midload_flag", flagA, 0);
    checkVal("midload_state", stateA, ST_IDLE);
    checkVal("midload_valid", validA, 0);
    #2 reset = 1'b0;
    tick();
    loadCoeffs(1'b0, LEN);
    fillImpulse();
    runStream(LEN, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
